// File: rtl/instr_tx_serializer.sv
// FIFO-buffered serializer for {ain,bin,func} instruction words, MSB first.
// Define INSTR_TX_PARITY_EN to append an even-parity bit (11-bit frames).
module instr_tx_serializer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_ain,
  input  logic [3:0]             in_bin,
  input  logic [1:0]             in_func,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic                   tx_bit,
  output logic                   tx_sof,
  output logic                   tx_eof,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
`ifdef INSTR_TX_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [3:0]    gapcnt_q, gapcnt_d;

  logic          push, pop, full, empty, last_bit, in_shift;
  logic [9:0]    head;
  logic [FW-1:0] head_frame;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign last_bit = (bitcnt_q == 4'(FW - 1));

`ifdef INSTR_TX_PARITY_EN
  assign head_frame = {head, ^head};
`else
  assign head_frame = head;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_d  = head_frame;
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tx_ready) begin
          shreg_d  = {shreg_q[FW-2:0], 1'b0};
          bitcnt_d = bitcnt_q + 4'd1;
          if (last_bit) begin
            if (GAP > 0) begin
              state_d  = S_GAP;
              gapcnt_d = 4'(GAP);
            end else if (!empty) begin
              pop      = 1'b1;
              shreg_d  = head_frame;
              bitcnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        gapcnt_d = gapcnt_q - 4'd1;
        // Final gap cycle also does the IDLE pop, so exactly GAP dead cycles separate frames.
        if (gapcnt_q <= 4'd1) begin
          if (!empty) begin
            pop      = 1'b1;
            shreg_d  = head_frame;
            bitcnt_d = '0;
            state_d  = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_ain, in_bin, in_func};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  assign in_shift = (state_q == S_SHIFT);
  assign tx_valid = in_shift;
  assign tx_bit   = in_shift & shreg_q[FW-1];
  assign tx_sof   = in_shift & (bitcnt_q == '0);
  assign tx_eof   = in_shift & last_bit;
  assign level    = level_q;
  assign busy     = ~empty | (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_tx_serializer.sv
// Bench for instr_tx_serializer: directed scenarios plus random traffic
// checked by a frame-level scoreboard.
module tb_instr_tx_serializer;

  localparam int DEPTH = 4;
`ifdef INSTR_TX_PARITY_EN
  localparam int FW = 11;
`else
  localparam int FW = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, tx_ready = 1'b0;
  logic [3:0] in_ain = '0, in_bin = '0;
  logic [1:0] in_func = '0;
  logic in_ready, tx_valid, tx_bit, tx_sof, tx_eof, busy;
  logic [$clog2(DEPTH):0] level;

  logic g_in_valid = 1'b0, g_tx_ready = 1'b1;
  logic [3:0] g_ain = '0, g_bin = '0;
  logic [1:0] g_func = '0;
  logic g_in_ready, g_tx_valid, g_tx_bit, g_tx_sof, g_tx_eof, g_busy;
  logic [$clog2(DEPTH):0] g_level;

  always #5 clk = ~clk;

  instr_tx_serializer #(.DEPTH(DEPTH), .GAP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ain(in_ain), .in_bin(in_bin), .in_func(in_func),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bit(tx_bit),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .level(level), .busy(busy)
  );

  instr_tx_serializer #(.DEPTH(DEPTH), .GAP(3)) dut_gap (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .in_ain(g_ain), .in_bin(g_bin), .in_func(g_func),
    .tx_ready(g_tx_ready), .tx_valid(g_tx_valid), .tx_bit(g_tx_bit),
    .tx_sof(g_tx_sof), .tx_eof(g_tx_eof), .level(g_level), .busy(g_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  exp_q[$];
  logic [15:0] rx_frame = '0;
  int          rx_cnt = 0;
  int          frames_done = 0;
  int          beats = 0;
  logic        rx_last_bit = 1'b0;
  logic        last_push = 1'b0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference frame: payload MSB first, optional even-parity bit at the tail.
  function automatic logic [FW-1:0] frame_of(input logic [9:0] w);
`ifdef INSTR_TX_PARITY_EN
    return {w, 1'($countones(w) % 2)};
`else
    return w;
`endif
  endfunction

  task automatic cyc();
    logic beat, push;
    logic [9:0] w;
    beat = tx_valid & tx_ready;
    push = in_valid & in_ready;
    if (!tx_valid) check1("flags_outside_valid", tx_sof | tx_eof, 1'b0);
    if (push) exp_q.push_back({in_ain, in_bin, in_func});
    if (beat) begin
      check1("sof_position", tx_sof, rx_cnt == 0);
      check1("eof_position", tx_eof, rx_cnt == FW - 1);
      rx_frame = {rx_frame[14:0], tx_bit};
      rx_cnt++;
      if (tx_eof) begin
        checkw("frame_len", 32'(rx_cnt), 32'(FW));
        check1("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          checkw("frame_bits", 32'(rx_frame[FW-1:0]), 32'(frame_of(w)));
        end
        rx_last_bit = tx_bit;
        frames_done++;
        rx_cnt = 0;
      end
    end
    last_push = push;
    if (beat) beats++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    tx_ready = 1'b1;
    in_valid = 1'b0;
    while ((busy || exp_q.size() != 0) && n < max) begin
      cyc();
      n++;
    end
    check1("drain_done", busy || (exp_q.size() != 0), 1'b0);
  endtask

  task automatic set_word(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    in_ain = a; in_bin = b; in_func = f;
  endtask

  initial begin
    logic [FW-1:0] f;
    logic b, s, e, stall, got;
    int k, bstart, fstart, ph_m, ph_g, gap_m, gap_g;
    logic any_valid;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_tx_valid", tx_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    checkw("rst_level", 32'(level), 0);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check1("post_rst_in_ready", in_ready, 1'b1);

    // Single frame with latency check
    tx_ready = 1'b1;
    in_valid = 1'b1;
    set_word(4'b1010, 4'b0011, 2'b00);
    f = frame_of({4'b1010, 4'b0011, 2'b00});
    cyc();
    in_valid = 1'b0;
    check1("lat_no_bit_yet", tx_valid, 1'b0);
    checkw("lat_level", 32'(level), 1);
    cyc();
    for (int i = 0; i < FW; i++) begin
      check1("f1_valid", tx_valid, 1'b1);
      check1("f1_bit", tx_bit, f[FW-1-i]);
      check1("f1_sof", tx_sof, i == 0);
      check1("f1_eof", tx_eof, i == FW - 1);
      cyc();
    end
    check1("f1_after_valid", tx_valid, 1'b0);
    check1("f1_after_busy", busy, 1'b0);

    // Fill to full under stall; the head sits in the shift register
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1;
      set_word(4'($urandom), 4'($urandom), 2'($urandom));
      check1("fill_ready", in_ready, 1'b1);
      cyc();
    end
    check1("full_in_ready", in_ready, 1'b0);
    checkw("full_level", 32'(level), DEPTH);
    check1("full_sof_held", tx_sof, 1'b1);
    set_word(4'b0110, 4'b1001, 2'b10);
    for (int i = 0; i < 3; i++) begin
      b = tx_bit;
      cyc();
      check1("hold_in_ready", in_ready, 1'b0);
      checkw("hold_level", 32'(level), DEPTH);
      check1("hold_bit", tx_bit, b);
    end
    tx_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3 * FW && !got; i++) begin
      cyc();
      if (in_ready) begin
        got = 1'b1;
        checkw("reassert_level", 32'(level), DEPTH - 1);
      end
    end
    check1("ready_reassert", got, 1'b1);
    cyc();
    in_valid = 1'b0;
    checkw("refill_level", 32'(level), DEPTH);
    drain(200);

    // Stall pattern mid-frame
    in_valid = 1'b1;
    set_word(4'b1111, 4'b0000, 2'b11);
    cyc();
    in_valid = 1'b0;
    cyc();
    bstart = beats;
    fstart = frames_done;
    for (k = 0; k < 6 * FW && frames_done == fstart; k++) begin
      tx_ready = (k % 2 == 0);
      b = tx_bit; s = tx_sof; e = tx_eof;
      stall = !tx_ready;
      cyc();
      if (stall) begin
        check1("stall_valid", tx_valid, 1'b1);
        check1("stall_bit", tx_bit, b);
        check1("stall_sof", tx_sof, s);
        check1("stall_eof", tx_eof, e);
      end
    end
    checkw("stall_frame_done", 32'(frames_done - fstart), 1);
    checkw("stall_beats", 32'(beats - bstart), 32'(FW));
    drain(50);

    // Inter-frame spacing: GAP=0 on dut, GAP=3 on dut_gap
    tx_ready = 1'b1;
    g_tx_ready = 1'b1;
    in_valid = 1'b1; g_in_valid = 1'b1;
    set_word(4'b0101, 4'b1100, 2'b01);
    g_ain = 4'b0101; g_bin = 4'b1100; g_func = 2'b01;
    cyc();
    set_word(4'b1001, 4'b0110, 2'b10);
    g_ain = 4'b1001; g_bin = 4'b0110; g_func = 2'b10;
    cyc();
    in_valid = 1'b0; g_in_valid = 1'b0;
    ph_m = 0; ph_g = 0; gap_m = 0; gap_g = 0;
    for (int i = 0; i < 100 && (ph_m != 2 || ph_g != 2); i++) begin
      if (ph_m == 1) begin
        if (tx_valid && tx_sof) ph_m = 2;
        else if (!tx_valid) gap_m++;
      end else if (ph_m == 0 && tx_valid && tx_eof) ph_m = 1;
      if (ph_g == 1) begin
        if (g_tx_valid && g_tx_sof) ph_g = 2;
        else if (!g_tx_valid) gap_g++;
      end else if (ph_g == 0 && g_tx_valid && g_tx_eof) ph_g = 1;
      cyc();
    end
    checkw("gap0_phase", 32'(ph_m), 2);
    checkw("gap0_cycles", 32'(gap_m), 0);
    checkw("gap3_phase", 32'(ph_g), 2);
    checkw("gap3_cycles", 32'(gap_g), 3);
    drain(100);
    for (int i = 0; i < 60 && g_busy; i++) cyc();
    check1("gap3_idle", g_busy, 1'b0);

    // Reset in the middle of a frame with words queued
    tx_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(4'($urandom), 4'($urandom), 2'($urandom));
      cyc();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 30 && rx_cnt != 5; i++) cyc();
    checkw("abort_at_bit5", 32'(rx_cnt), 5);
    checkw("abort_queued", 32'(level), 2);
    rst = 1'b1;
    #1;
    check1("abort_tx_valid", tx_valid, 1'b0);
    check1("abort_tx_bit", tx_bit, 1'b0);
    check1("abort_sof_eof", tx_sof | tx_eof, 1'b0);
    checkw("abort_level", 32'(level), 0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_in_ready", in_ready, 1'b0);
    exp_q.delete();
    rx_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      any_valid = any_valid | tx_valid | busy;
    end
    check1("abort_silent", any_valid, 1'b0);
    in_valid = 1'b1;
    set_word(4'b0111, 4'b1000, 2'b01);
    cyc();
    in_valid = 1'b0;
    drain(50);

`ifdef INSTR_TX_PARITY_EN
    in_valid = 1'b1;
    set_word(4'b0001, 4'b0000, 2'b00);
    cyc();
    drain(50);
    check1("parity_odd_payload", rx_last_bit, 1'b1);
    in_valid = 1'b1;
    set_word(4'b0011, 4'b0000, 2'b00);
    cyc();
    drain(50);
    check1("parity_even_payload", rx_last_bit, 1'b0);
`endif

    // Random traffic with producer hold and random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 1) == 1);
        set_word(4'($urandom), 4'($urandom), 2'($urandom));
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain(600);
    checkw("final_level", 32'(level), 0);
    checkw("final_partial", 32'(rx_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
